inv_shift_rows_pipe: RTL and testbench
======================================

INV_SHIFT_ROWS_PIPE -- requirements
Module: inv_shift_rows_pipe

Interface
REQ-001 Parameter: CNT_W, 8, width of the accepted-block counter (legal range 4..32).
REQ-002 Ports: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Ports: rst  input  1  synchronous, active-high reset.
REQ-004 Ports: flush  input  1  synchronous clear of buffered blocks; the block counter is unaffected.
REQ-005 Ports: in_valid  input  1  in_data holds a block.
REQ-006 Ports: in_ready  output  1  block can accept; registered.
REQ-007 Ports: in_data  input  128  AES state, column-major; byte k = bits [8k+7:8k]; row r, column c is byte 4c+r.
REQ-008 Ports: out_valid  output  1  out_data holds a transformed block.
REQ-009 Ports: out_ready  input  1  downstream accepts.
REQ-010 Ports: out_data  output  128  InvShiftRows of the accepted block; registered.
REQ-011 Ports: blk_cnt  output  CNT_W  count of accepted input blocks.

Function
REQ-012 The output byte mapping SHALL be out byte 4c+r = in byte 4*((c-r) mod 4)+r, for r,c in 0..3.
REQ-013 Row 0 SHALL pass unchanged; rows 1, 2 and 3 SHALL rotate right by 1, 2 and 3 columns.
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Storage SHALL be a two-entry skid buffer: a main register (drives out_*) and a skid register.
REQ-016 The transform SHALL be applied before storage, so both registers hold transformed data.
REQ-017 Latency SHALL be 1 cycle: a block accepted in cycle N is presented with out_valid high in cycle N+1 when main was empty or drained in cycle N.
REQ-018 Throughput SHALL be 1 block/cycle while out_ready stays high.
REQ-019 States: EMPTY (main and skid empty), ONE (main full), TWO (main and skid full).
REQ-020 EMPTY -> ONE on an input transfer.
REQ-021 ONE -> ONE on input and output transfer together, or on neither.
REQ-022 ONE -> TWO on an input transfer with no output transfer; the new block goes to skid.
REQ-023 ONE -> EMPTY on an output transfer with no input transfer.
REQ-024 TWO -> ONE on an output transfer; skid moves to main.
REQ-025 in_ready SHALL be low in TWO and high in EMPTY and ONE.
REQ-026 in_ready SHALL depend only on registered state, with no combinational path from out_ready.
REQ-027 out_valid SHALL be high exactly in ONE and TWO.
REQ-028 out_data SHALL be held stable while out_valid && !out_ready.
REQ-029 Blocks SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-030 blk_cnt SHALL increment by 1 on each input transfer and wrap from 2^CNT_W-1 to 0.
REQ-031 flush SHALL force EMPTY next cycle.
REQ-032 An input transfer in the same cycle as flush SHALL be discarded but still counted in blk_cnt.
REQ-033 in_data and out_ready SHALL be ignored when the corresponding valid is low.

Reset
REQ-034 When rst is high at a clock edge, the block SHALL enter EMPTY with out_valid=0, in_ready=0, out_data=0, blk_cnt=0, and skid contents=0.
REQ-035 in_ready SHALL rise the first cycle after rst deasserts.
REQ-036 rst SHALL take priority over flush and over any transfer in the same cycle.
REQ-037 A reset mid-stream SHALL discard all buffered blocks.

Structure
REQ-038 Shared package aes_pkg SHALL hold the 128-bit state typedef, byte-width constants, and the column-major byte-index convention, shared with the forward-cipher blocks.
REQ-039 One purely combinational sub-module inv_shift_rows SHALL implement REQ-012; it holds no registers.
REQ-040 The skid/handshake control SHALL live in inv_shift_rows_pipe.

Verification
REQ-041 Mapping: in_data=128'h0f0e0d0c0b0a09080706050403020100 with out_ready=1 SHALL give out_data=128'h0306090c0f0205080b0e0104070a0d00 one cycle later.
REQ-042 Round-trip: 1000 random blocks through the forward shift_rows then this block SHALL return the originals in order, with blk_cnt=1000 mod 256.
REQ-043 Backpressure: hold out_ready=0 and offer 3 blocks A, B, C. Required: A and B are accepted; in_ready goes low after B; C is held; out_data stays at InvSR(A). Then raise out_ready; outputs SHALL be A, B, C in order with no bubble after B.
REQ-044 Streaming: continuous in_valid/out_ready=1 for 16 cycles SHALL give 16 outputs on consecutive cycles, first output at cycle+1.
REQ-045 Flush/reset: from TWO, assert flush (then, separately, rst). Next cycle SHALL show out_valid=0. With flush, blk_cnt is unchanged; with rst, blk_cnt=0 and in_ready=0.
REQ-046 Wrap: CNT_W=4 with 17 accepted blocks SHALL give blk_cnt=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: 128-bit state type, byte geometry and the
// column-major byte-index convention (row r, column c -> byte 4c+r).
package aes_pkg;

  localparam int unsigned ByteW   = 8;
  localparam int unsigned NumRows = 4;
  localparam int unsigned NumCols = 4;
  localparam int unsigned StateW  = ByteW * NumRows * NumCols;

  typedef logic [StateW-1:0] state_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } pipe_st_e;

  function automatic int unsigned byte_idx(int unsigned r, int unsigned c);
    return NumRows * c + r;
  endfunction

endpackage

// File: rtl/inv_shift_rows_pipe_if.sv
// Valid/ready block stream in, transformed block stream out, plus the
// accepted-block counter. The pipe uses slave, its environment uses master.
interface inv_shift_rows_pipe_if #(
  parameter int unsigned CNT_W = 8
);
  import aes_pkg::*;

  logic             in_valid;
  logic             in_ready;
  state_t           in_data;
  logic             out_valid;
  logic             out_ready;
  state_t           out_data;
  logic [CNT_W-1:0] blk_cnt;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, blk_cnt
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, blk_cnt
  );

endinterface

// File: rtl/inv_shift_rows.sv
// Combinational AES InvShiftRows: row r of the state rotates right by r columns.
module inv_shift_rows
  import aes_pkg::*;
(
  input  state_t state_i,
  output state_t state_o
);

  for (genvar r = 0; r < NumRows; r++) begin : g_row
    for (genvar c = 0; c < NumCols; c++) begin : g_col
      localparam int unsigned SrcCol = (c + NumCols - r) % NumCols;
      assign state_o[ByteW*byte_idx(r, c) +: ByteW] =
          state_i[ByteW*byte_idx(r, SrcCol) +: ByteW];
    end
  end

endmodule

// File: rtl/inv_shift_rows_pipe.sv
// One-cycle InvShiftRows stage behind a two-entry skid buffer; in_ready comes
// straight from a flop so there is no combinational path from out_ready.
module inv_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  inv_shift_rows_pipe_if.slave bus
);

  pipe_st_e         state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  state_t           main_q;
  state_t           skid_q;
  state_t           xform;
  logic [CNT_W-1:0] cnt_q;
  logic             in_xfer;
  logic             out_xfer;

  inv_shift_rows u_isr (
    .state_i (bus.in_data),
    .state_o (xform)
  );

  assign in_xfer  = bus.in_valid & in_ready_q;
  assign out_xfer = out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      // Counted even when flush discards the block in the same cycle.
      if (in_xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        state_q     <= StEmpty;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          StEmpty: begin
            in_ready_q <= 1'b1;
            if (in_xfer) begin
              main_q      <= xform;
              out_valid_q <= 1'b1;
              state_q     <= StOne;
            end
          end
          StOne: begin
            if (in_xfer && out_xfer) begin
              main_q <= xform;
            end else if (in_xfer) begin
              skid_q     <= xform;
              in_ready_q <= 1'b0;
              state_q    <= StTwo;
            end else if (out_xfer) begin
              out_valid_q <= 1'b0;
              state_q     <= StEmpty;
            end
          end
          StTwo: begin
            if (out_xfer) begin
              main_q     <= skid_q;
              in_ready_q <= 1'b1;
              state_q    <= StOne;
            end
          end
          default: begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.blk_cnt   = cnt_q;

endmodule

// File: tb/tb_inv_shift_rows_pipe.sv
// Self-checking bench: queue-based reference of the buffered stream compared every
// cycle, plus directed literal checks for mapping, backpressure, flush, reset, wrap.
module tb_inv_shift_rows_pipe;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  inv_shift_rows_pipe_if #(.CNT_W(8)) bus ();
  inv_shift_rows_pipe_if #(.CNT_W(4)) bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_data   = bus.in_data;
  assign bus4.out_ready = bus.out_ready;

  inv_shift_rows_pipe #(.CNT_W(8)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  inv_shift_rows_pipe #(.CNT_W(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus4.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference transforms on a 4x4 byte matrix.
  function automatic state_t m_inv_sr(state_t s);
    logic [7:0] m[4][4];
    logic [7:0] o[4][4];
    state_t     res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = s[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[r][(c+r)%4] = m[r][c];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(4*c+r) +: 8] = o[r][c];
    return res;
  endfunction

  function automatic state_t m_sr(state_t s);
    logic [7:0] m[4][4];
    state_t     res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[r][c] = s[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[8*(4*c+r) +: 8] = m[r][(c+r)%4];
    return res;
  endfunction

  function automatic state_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: queue of blocks the DUT must still present, in order.
  state_t      exp_q[$];
  int unsigned m_cnt        = 0;
  logic        m_rdy        = 1'b0;
  bit          last_in_xfer = 1'b0;
  bit          rt_mode      = 1'b0;
  state_t      rt_orig;
  bit          chk_en       = 1'b0;

  always @(posedge clk) begin
    bit ix;
    bit ox;
    ix = bus.in_valid && m_rdy;
    ox = (exp_q.size() > 0) && bus.out_ready;
    if (rst) begin
      exp_q.delete();
      m_cnt        <= 0;
      m_rdy        <= 1'b0;
      last_in_xfer <= 1'b0;
    end else begin
      last_in_xfer <= ix;
      if (ix) m_cnt <= m_cnt + 1;
      if (flush) begin
        exp_q.delete();
        m_rdy <= 1'b1;
      end else begin
        if (ox) void'(exp_q.pop_front());
        if (ix) exp_q.push_back(rt_mode ? rt_orig : m_inv_sr(bus.in_data));
        m_rdy <= (exp_q.size() < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("in_ready", bus.in_ready, m_rdy);
      if (exp_q.size() > 0) check("out_data", bus.out_data, exp_q[0]);
      check("blk_cnt", bus.blk_cnt, m_cnt[7:0]);
      check("blk_cnt_w4", bus4.blk_cnt, m_cnt[3:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  localparam state_t MapIn  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam state_t MapOut = 128'h0306090c0f0205080b0e0104070a0d00;

  initial begin
    state_t a, b, c, x;
    int     accepted;
    int     cycles;

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    chk_en = 1'b1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_blk_cnt", bus.blk_cnt, 0);
    rst = 1'b0;
    cyc();
    check("in_ready_after_rst", bus.in_ready, 1);

    // Pin the reference functions to hand-computed values.
    check("model_inv_sr", m_inv_sr(MapIn), MapOut);
    check("model_round_trip", m_inv_sr(m_sr(MapIn)), MapIn);

    // Single-block mapping, one-cycle latency.
    bus.in_data   = MapIn;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    check("map_valid", bus.out_valid, 1);
    check("map_literal", bus.out_data, MapOut);

    // Streaming: 16 back-to-back blocks, outputs on consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rnd_blk();
      cyc();
      check("stream_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    cyc();
    check("stream_drained", bus.out_valid, 0);
    check("cnt_17", bus.blk_cnt, 17);
    check("wrap_w4", bus4.blk_cnt, 1);

    // Backpressure: A and B fill the buffer, C waits.
    a = rnd_blk();
    b = rnd_blk();
    c = rnd_blk();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    cyc();
    bus.in_data = b;
    cyc();
    check("bp_in_ready_low", bus.in_ready, 0);
    bus.in_data = c;
    check("bp_hold_a", bus.out_data, m_inv_sr(a));
    cyc();
    cyc();
    check("bp_still_a", bus.out_data, m_inv_sr(a));
    check("bp_still_full", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    cyc();
    check("bp_out_b_valid", bus.out_valid, 1);
    check("bp_out_b", bus.out_data, m_inv_sr(b));
    cyc();
    bus.in_valid = 1'b0;
    check("bp_out_c_valid", bus.out_valid, 1);
    check("bp_out_c", bus.out_data, m_inv_sr(c));
    cyc();
    check("bp_empty", bus.out_valid, 0);
    check("bp_cnt", bus.blk_cnt, 20);

    // Flush from TWO keeps the counter.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = rnd_blk();
    cyc();
    bus.in_data = rnd_blk();
    cyc();
    check("fl_full", bus.in_ready, 0);
    flush = 1'b1;
    cyc();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_cnt", bus.blk_cnt, 22);
    check("fl_in_ready", bus.in_ready, 1);

    // Transfer coinciding with flush: discarded but counted.
    bus.in_valid = 1'b1;
    bus.in_data  = rnd_blk();
    cyc();
    flush       = 1'b1;
    bus.in_data = rnd_blk();
    cyc();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("flx_out_valid", bus.out_valid, 0);
    check("flx_cnt", bus.blk_cnt, 24);

    // Reset from TWO, with flush and out_ready also high.
    bus.in_valid = 1'b1;
    bus.in_data  = rnd_blk();
    cyc();
    bus.in_data = rnd_blk();
    cyc();
    rst           = 1'b1;
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    check("rs_out_valid", bus.out_valid, 0);
    check("rs_in_ready", bus.in_ready, 0);
    check("rs_cnt", bus.blk_cnt, 0);
    check("rs_out_data", bus.out_data, 0);
    rst          = 1'b0;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    cyc();

    // Round trip: forward ShiftRows then DUT must return the originals in order.
    rt_mode  = 1'b1;
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      if (!bus.in_valid || last_in_xfer) begin
        if ($urandom_range(0, 3) != 0) begin
          x            = rnd_blk();
          rt_orig      = x;
          bus.in_data  = m_sr(x);
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      cycles++;
      if (last_in_xfer) accepted++;
    end
    bus.in_valid = 1'b0;
    if (accepted < 1000) begin
      checks++;
      errors++;
      $display("FAIL rt_timeout: accepted %0d blocks, required 1000", accepted);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    check("rt_drained", bus.out_valid, 0);
    check("rt_cnt", bus.blk_cnt, 232);
    check("rt_cnt_w4", bus4.blk_cnt, 8);
    rt_mode = 1'b0;

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
